cpu_clock_ctrl: RTL and testbench

- Generates the CPU clock from the board clock, replacing the free-running divider that currently drives the CPU core.
- Adds run/stop and single-step control from two push-buttons, and a halt input fed back from the CPU.
- Sits directly upstream of the CPU core. Its cpu_clk output connects to the core's clock input.
- Guarantees glitch-free, full-width cpu_clk pulses: no runt highs or lows on any state change.

---
 rtl/cpu_clock_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// CPU clock generator: divides the board clock and gates it with run/stop,
// single-step and CPU halt control, only ever changing state on a falling toggle.

module cpu_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned DB_W            = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic            level_prev_q;
  logic            press_q;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // Counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

module cpu_clock_ctrl #(
  parameter int unsigned DIVIDER         = 1200000,
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned DB_W            = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       halt,
  output logic       cpu_clk,
  output logic       cpu_tick,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic             run_press;
  logic             step_press;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;
  logic             cpu_clk_q;
  logic             cpu_clk_d;
  logic             clk_prev_q;
  logic             tick_q;
  logic             running_q;
  logic             stop_pend_q;
  logic             stop_pend_d;
  logic             wrap;
  logic             fall;

  cpu_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_run_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (run_btn),
    .press_o (run_press)
  );

  cpu_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_step_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (step_btn),
    .press_o (step_press)
  );

  assign wrap = (div_q == CNT_W'(DIVIDER));
  assign fall = wrap & cpu_clk_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cpu_clk_d   = cpu_clk_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      STOP: begin
        div_d       = '0;
        cpu_clk_d   = 1'b0;
        stop_pend_d = 1'b0;
        if (run_press) begin
          state_d = RUN;
        end else if (step_press) begin
          state_d = STEP;
        end
      end
      RUN, STEP: begin
        if (wrap) begin
          div_d     = '0;
          cpu_clk_d = ~cpu_clk_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (state_q == RUN && run_press) begin
          stop_pend_d = 1'b1;
        end
        // Leave only after the low-going toggle so the last high is full width.
        if (fall) begin
          stop_pend_d = 1'b0;
          if (halt) begin
            state_d = HALT;
          end else if (state_q == STEP || stop_pend_q || run_press) begin
            state_d = STOP;
          end
        end
      end
      default: begin
        div_d       = '0;
        cpu_clk_d   = 1'b0;
        stop_pend_d = 1'b0;
        if (run_press && !halt) begin
          state_d = STOP;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STOP;
      div_q       <= '0;
      cpu_clk_q   <= 1'b0;
      clk_prev_q  <= 1'b0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cpu_clk_q   <= cpu_clk_d;
      clk_prev_q  <= cpu_clk_q;
      tick_q      <= cpu_clk_q & ~clk_prev_q;
      running_q   <= (state_d == RUN);
      stop_pend_q <= stop_pend_d;
    end
  end

  assign cpu_clk  = cpu_clk_q;
  assign cpu_tick = tick_q;
  assign running  = running_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: expected output changes are queued with
// the cycle they must appear in; a monitor compares every observed change.

module tb_cpu_clock_ctrl;

  logic       clk;
  logic       rst;
  logic       run_btn;
  logic       step_btn;
  logic       halt;
  logic       cpu_clk;
  logic       cpu_tick;
  logic       running;
  logic [1:0] state;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  v;   // {state, cpu_clk, cpu_tick, running}
  } ev_t;

  ev_t         exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  prev  = '0;

  cpu_clock_ctrl #(
    .DIVIDER         (3),
    .CNT_W           (4),
    .DEBOUNCE_CYCLES (4),
    .DB_W            (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run_btn  (run_btn),
    .step_btn (step_btn),
    .halt     (halt),
    .cpu_clk  (cpu_clk),
    .cpu_tick (cpu_tick),
    .running  (running),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [4:0] cur;
    ev_t        e;
    cur = {state, cpu_clk, cpu_tick, running};
    if (mon_en && cur != prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v != cur) begin
          n_err++;
          $display("FAIL event got cyc=%0d v=%b required cyc=%0d v=%b", cyc, cur, e.cyc, e.v);
        end
      end
    end
    prev = cur;
  end

  task automatic push_ev(input int unsigned c, input logic [1:0] st,
                         input logic ck, input logic tk, input logic rn);
    ev_t e;
    e.cyc = c;
    e.v   = {st, ck, tk, rn};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic hold_btns(input logic r, input logic s);
    run_btn  = r;
    step_btn = s;
    repeat (10) @(negedge clk);
    run_btn  = 1'b0;
    step_btn = 1'b0;
  endtask

  initial begin
    int unsigned c;
    int unsigned e;
    rst      = 1'b1;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state), 0);
    chk("reset_cpu_clk", 32'(cpu_clk), 0);
    chk("reset_tick", 32'(cpu_tick), 0);
    chk("reset_running", 32'(running), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Run press: RUN 8 cycles after raw edge, then 4 full periods; stop press lands in the 4th high.
    c = cyc;
    e = c + 8;
    push_ev(e, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int unsigned k = 0; k < 4; k++) begin
      push_ev(e + 4 + 8 * k, 2'd1, 1'b1, 1'b0, 1'b1);
      push_ev(e + 5 + 8 * k, 2'd1, 1'b1, 1'b1, 1'b1);
      push_ev(e + 6 + 8 * k, 2'd1, 1'b1, 1'b0, 1'b1);
      if (k < 3) push_ev(e + 8 + 8 * k, 2'd1, 1'b0, 1'b0, 1'b1);
      else       push_ev(e + 8 + 8 * k, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    hold_btns(1'b1, 1'b0);
    wait_until(e + 21);
    hold_btns(1'b1, 1'b0);
    wait_until(e + 45);

    // Single step: one full period, one tick, back to STOP.
    c = cyc;
    e = c + 8;
    push_ev(e,     2'd2, 1'b0, 1'b0, 1'b0);
    push_ev(e + 4, 2'd2, 1'b1, 1'b0, 1'b0);
    push_ev(e + 5, 2'd2, 1'b1, 1'b1, 1'b0);
    push_ev(e + 6, 2'd2, 1'b1, 1'b0, 1'b0);
    push_ev(e + 8, 2'd0, 1'b0, 1'b0, 1'b0);
    hold_btns(1'b0, 1'b1);
    wait_until(e + 20);

    // Bouncing run button never settles long enough.
    for (int unsigned k = 0; k < 5; k++) begin
      run_btn = 1'b1;
      repeat (2) @(negedge clk);
      run_btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("bounce_state", 32'(state), 0);

    // Halt at falling toggle; run press ignored while halt is high.
    c = cyc;
    e = c + 8;
    push_ev(e,      2'd1, 1'b0, 1'b0, 1'b1);
    push_ev(e + 4,  2'd1, 1'b1, 1'b0, 1'b1);
    push_ev(e + 5,  2'd1, 1'b1, 1'b1, 1'b1);
    push_ev(e + 6,  2'd1, 1'b1, 1'b0, 1'b1);
    push_ev(e + 8,  2'd3, 1'b0, 1'b0, 1'b0);
    push_ev(e + 40, 2'd0, 1'b0, 1'b0, 1'b0);
    hold_btns(1'b1, 1'b0);
    wait_until(e + 6);
    halt = 1'b1;
    wait_until(e + 10);
    hold_btns(1'b1, 1'b0);
    wait_until(e + 30);
    chk("halt_hold_state", 32'(state), 3);
    halt = 1'b0;
    wait_until(e + 32);
    hold_btns(1'b1, 1'b0);
    wait_until(e + 52);

    // Simultaneous run+step: run wins.
    c = cyc;
    push_ev(c + 8,  2'd1, 1'b0, 1'b0, 1'b1);
    push_ev(c + 12, 2'd1, 1'b1, 1'b0, 1'b1);
    push_ev(c + 13, 2'd1, 1'b1, 1'b1, 1'b1);
    push_ev(c + 14, 2'd1, 1'b1, 1'b0, 1'b1);
    hold_btns(1'b1, 1'b1);
    wait_until(c + 15);
    mon_en = 1'b0;
    chk("pre_rst_cpu_clk", 32'(cpu_clk), 1);
    chk("events_pending", exp_q.size(), 0);

    // Asynchronous reset mid-high, checked before the next clk edge.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cpu_clk", 32'(cpu_clk), 0);
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_running", 32'(running), 0);
    chk("async_rst_tick", 32'(cpu_tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
